rnn_seq_ctrl: RTL

//  Sequencer that drives the rnn accelerator's register-write port (write/addr/data_in).

---
 rtl/rnn_seq_ctrl_pkg.sv | 28 ++
 rtl/rnn_seq_ctrl_if.sv | 26 ++
 rtl/rnn_seq_ctrl_sync_fifo.sv | 48 ++++
 rtl/rnn_seq_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rnn_seq_ctrl_pkg.sv
// Shared definitions for the rnn register-write sequencer.
//   - rnn register map (word addresses on the rnn register-write port)
//   - sequencer FSM state encoding
//   - small elaboration helper
package rnn_seq_ctrl_pkg;

    localparam logic [31:0] RNN_ADDR_CTRL  = 32'd0;
    localparam logic [31:0] RNN_ADDR_INPUT = 32'd1;
    localparam logic [31:0] RNN_ADDR_W0    = 32'd2;
    localparam logic [31:0] RNN_ADDR_W1    = 32'd3;
    localparam logic [31:0] RNN_ADDR_RBIAS = 32'd4;
    localparam logic [31:0] RNN_ADDR_DENSE = 32'd5;
    localparam logic [31:0] RNN_ADDR_DBIAS = 32'd6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IN,
        KICK,
        WAIT,
        ACK,
        RELEASE
    } seq_state_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/rnn_seq_ctrl_if.sv
// Host character stream plus rnn register-write port.
//   in_valid/in_ready/in_data/in_last : host -> sequencer character push
//   m_write/m_addr/m_data             : sequencer -> rnn register writes
// master: host side (drives the character stream, observes the write port)
// slave : sequencer side
interface rnn_seq_ctrl_if #(
    parameter int IN_LEN = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [16*IN_LEN-1:0]   in_data;
    logic                   in_last;
    logic                   m_write;
    logic [31:0]            m_addr;
    logic [31:0]            m_data;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, m_write, m_addr, m_data
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, m_write, m_addr, m_data
    );
endinterface

// File: rtl/rnn_seq_ctrl_sync_fifo.sv
// Single-clock FIFO with registered storage and full/empty flags.
//   clk, rst      : clock, async active-high reset (flushes pointers)
//   push, wdata   : write request; ignored while full
//   pop, rdata    : read request; rdata shows the head entry whenever !empty
//   full, empty   : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    // A full FIFO refuses a push even if the same cycle pops.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/rnn_seq_ctrl.sv
// Sequencer driving the rnn accelerator register-write port, one character
// at a time: load input vector -> start -> settle -> activation ack -> release.
//   clk, rst   : clock, async active-high reset (rnn must share it as rst_n=~rst)
//   bus        : host character stream in, rnn write port out
//   busy       : FSM not idle or characters still queued
//   char_done  : pulse in the RELEASE cycle of every character
//   seq_done   : pulse with char_done for a character flagged last
//   char_count : characters completed in the current sequence (saturating)
//
// state   | meaning
// IDLE    | waiting for a queued character; pops it into the cur regs
// LOAD_IN | writes element idx of the input vector (addr 1), IN_LEN cycles
// KICK    | ctrl write, rnn LOAD -> START
// WAIT    | SETTLE_CYCLES quiet cycles while the rnn computes
// ACK     | ctrl write, rnn ACTIVATION -> DONE
// RELEASE | ctrl write, rnn DONE -> LOAD; character complete
module rnn_seq_ctrl
    import rnn_seq_ctrl_pkg::*;
#(
    parameter int IN_LEN        = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter int SETTLE_CYCLES = 40
) (
    input  logic         clk,
    input  logic         rst,
    rnn_seq_ctrl_if.slave bus,
    output logic         busy,
    output logic         char_done,
    output logic         seq_done,
    output logic [15:0]  char_count
);
    localparam int DW = 16 * IN_LEN;
    localparam int FW = DW + 1;
    localparam int IW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    generate
        if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
            $error("rnn_seq_ctrl: FIFO_DEPTH must be a power of 2 >= 2");
        end
        if (IN_LEN < 1 || IN_LEN > 256) begin : g_bad_len
            $error("rnn_seq_ctrl: IN_LEN must be 1..256");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("rnn_seq_ctrl: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [FW-1:0]   fifo_rdata;
    logic [DW-1:0]   cur_data;
    logic            cur_last;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   settle_cnt;
    logic [15:0]     elem;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .wdata ({bus.in_last, bus.in_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.in_ready = !fifo_full;
    assign busy         = (state != IDLE) || !fifo_empty;
    assign elem         = cur_data[{idx, 4'b0000} +: 16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = LOAD_IN;
            LOAD_IN: if (idx == IW'(IN_LEN - 1)) state_nxt = KICK;
            KICK:    state_nxt = WAIT;
            WAIT:    if (settle_cnt == '0) state_nxt = ACK;
            ACK:     state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop    = 1'b0;
        bus.m_write = 1'b0;
        bus.m_addr  = '0;
        bus.m_data  = '0;
        char_done   = 1'b0;
        seq_done    = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            LOAD_IN: begin
                bus.m_write = 1'b1;
                bus.m_addr  = RNN_ADDR_INPUT;
                bus.m_data  = {8'h00, 8'(idx), elem};
            end
            KICK, ACK: begin
                bus.m_write = 1'b1;
                bus.m_addr  = RNN_ADDR_CTRL;
            end
            RELEASE: begin
                bus.m_write = 1'b1;
                bus.m_addr  = RNN_ADDR_CTRL;
                char_done   = 1'b1;
                seq_done    = cur_last;
            end
            default: ;
        endcase
    end

    // Datapath: current character, element index, settle down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_data   <= '0;
            cur_last   <= 1'b0;
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur_data <= fifo_rdata[DW-1:0];
                        cur_last <= fifo_rdata[DW];
                    end
                    idx <= '0;
                end
                LOAD_IN: begin
                    if (idx == IW'(IN_LEN - 1)) idx <= '0;
                    else                        idx <= idx + 1'b1;
                end
                KICK: settle_cnt <= CW'(SETTLE_CYCLES - 1);
                WAIT: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Count on ACK -> RELEASE so the RELEASE cycle already shows the
    // completed total; clear the cycle after the last character finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_count <= '0;
        end else if (state == ACK) begin
            if (char_count != 16'hFFFF) char_count <= char_count + 16'd1;
        end else if (state == RELEASE && cur_last) begin
            char_count <= '0;
        end
    end
endmodule
